demux1to64_pipelined: RTL and testbench

- Write-direction counterpart of the 64:1 pipelined mux.
- Accepts one data bit plus a 6-bit index per cycle. Routes the bit through a 3-stage radix-4 decode tree and writes it into the addressed position of a 64-bit holding register; all other positions keep their values.
- Tracks which positions have been written since the last clear, so the assembled word can be handed to downstream logic as a complete 64-bit vector.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_stage.sv | 56 +++++
 rtl/demux1to64_pipelined.sv | 82 ++++++++
 tb/tb_demux1to64_pipelined.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared types and helpers for the 1:64 pipelined demux.
//   SEL_W / N     : index width and output word width (6 / 64)
//   word_t        : 64-bit output word
//   demux_beat_t  : one pipeline beat {valid, data, sel}
//   dec2to4       : 2-bit index to 4-bit one-hot
package demux_pkg;

  localparam int SEL_W = 6;
  localparam int N     = 2 ** SEL_W;

  typedef logic [N-1:0] word_t;

  typedef struct packed {
    logic             valid;
    logic             data;
    logic [SEL_W-1:0] sel;
  } demux_beat_t;

  function automatic logic [3:0] dec2to4(input logic [1:0] s);
    dec2to4 = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/demux_stage.sv
// demux_stage: one radix-4 level of the write decode tree.
//   clk, rst, clear : clock, sync reset, sync flush (both zero the stage)
//   beat_in         : incoming beat {valid, data, sel}
//   en_in           : enable vector from the previous level (EN_IN_W bits)
//   beat_out        : registered beat
//   en_out          : registered enable, 4x wider, refined by this level's
//                     two sel bits
// STAGE selects which sel pair is decoded: 0 -> sel[5:4], 1 -> sel[3:2],
// 2 -> sel[1:0]. Enable bit g*4+k means "previous group g, sub-index k",
// so after the last level bit i is set exactly when sel == i.
module demux_stage
  import demux_pkg::*;
#(
  parameter int STAGE   = 0,
  parameter int EN_IN_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  demux_beat_t            beat_in,
  input  logic [EN_IN_W-1:0]     en_in,
  output demux_beat_t            beat_out,
  output logic [4*EN_IN_W-1:0]   en_out
);

  localparam int LSB = SEL_W - 2 * (STAGE + 1);

  logic [3:0]           dec;
  logic [4*EN_IN_W-1:0] en_next;

  assign dec = dec2to4(beat_in.sel[LSB +: 2]);

  // Gating by valid keeps an unknown sel on a bubble from reaching the
  // enable vector, so it can never disturb the holding register.
  always_comb begin
    en_next = '0;
    if (beat_in.valid) begin
      for (int g = 0; g < EN_IN_W; g++) begin
        for (int k = 0; k < 4; k++) begin
          en_next[g*4+k] = en_in[g] & dec[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_out <= '0;
      en_out   <= '0;
    end else begin
      beat_out <= beat_in;
      en_out   <= en_next;
    end
  end

endmodule

// File: rtl/demux1to64_pipelined.sv
// demux1to64_pipelined: writes one bit per cycle into an addressed position
// of a 64-bit holding register through a 3-level radix-4 decode pipeline.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (highest priority)
//   in_valid  : qualifies sel/in this cycle
//   sel       : target bit index
//   in        : data bit
//   clear     : synchronous flush of out, written and in-flight writes
//   out       : assembled word
//   out_valid : one-cycle pulse per write landing in out
//   written   : sticky "written since clear" mask
//   full      : registered &written
// A beat presented at edge t lands in out/written/out_valid at edge t+3.
// Only SEL_W = 6 is supported.
module demux1to64_pipelined #(
  parameter int          SEL_W   = 6,
  parameter logic [63:0] RST_VAL = 64'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in,
  input  logic                    clear,
  output logic [(2**SEL_W)-1:0]   out,
  output logic                    out_valid,
  output logic [(2**SEL_W)-1:0]   written,
  output logic                    full
);
  import demux_pkg::*;

  demux_beat_t beat_in, s1_beat, s2_beat, s3_beat;
  logic [3:0]  s1_en;
  logic [15:0] s2_en;
  word_t       s3_en;

  assign beat_in = '{valid: in_valid, data: in, sel: sel};

  demux_stage #(.STAGE(0), .EN_IN_W(1)) u_s1 (
    .clk(clk), .rst(rst), .clear(clear),
    .beat_in(beat_in), .en_in(1'b1),
    .beat_out(s1_beat), .en_out(s1_en)
  );

  demux_stage #(.STAGE(1), .EN_IN_W(4)) u_s2 (
    .clk(clk), .rst(rst), .clear(clear),
    .beat_in(s1_beat), .en_in(s1_en),
    .beat_out(s2_beat), .en_out(s2_en)
  );

  demux_stage #(.STAGE(2), .EN_IN_W(16)) u_s3 (
    .clk(clk), .rst(rst), .clear(clear),
    .beat_in(s2_beat), .en_in(s2_en),
    .beat_out(s3_beat), .en_out(s3_en)
  );

  // The index is fully encoded in s3_en by now; the final sel is not needed.
  logic unused_s3_sel;
  assign unused_s3_sel = ^s3_beat.sel;

  // clear on the same edge as an S3 write wins: the write is dropped.
  // full looks at the pre-edge mask, so it rises one cycle after written
  // reaches all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out       <= RST_VAL;
      written   <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s3_beat.valid;
      full      <= &written;
      for (int i = 0; i < N; i++) begin
        if (s3_en[i]) begin
          out[i]     <= s3_beat.data;
          written[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1to64_pipelined.sv
module tb_demux1to64_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  sel;
  logic        din;
  logic        clear;
  logic [63:0] out;
  logic        out_valid;
  logic [63:0] written;
  logic        full;

  int total = 0;
  int bad   = 0;

  demux1to64_pipelined #(.SEL_W(6), .RST_VAL(64'h0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .in(din),
    .clear(clear), .out(out), .out_valid(out_valid), .written(written),
    .full(full)
  );

  always #5 clk = ~clk;

  // one active edge, then settle; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; sel = 6'd0; din = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (out !== 64'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 64'h0); end
    total++; if (written !== 64'h0) begin bad++; $display("FAIL reset_written got=%h exp=%h", written, 64'h0); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_sweep();
    logic [63:0] pat;
    int first_ov, n_ov, last_ov, wr_all_step, full_step;
    pat = 64'hA5A5_A5A5_F0F0_0F0F;
    first_ov = -1; n_ov = 0; last_ov = -1; wr_all_step = -1; full_step = -1;
    for (int s = 0; s < 72; s++) begin
      if (s < 64) begin
        in_valid = 1'b1; sel = 6'(s); din = pat[s];
      end else begin
        idle();
      end
      step();
      if (out_valid === 1'b1) begin
        if (first_ov < 0) first_ov = s;
        n_ov++;
        last_ov = s;
      end
      if (written === {64{1'b1}} && wr_all_step < 0) wr_all_step = s;
      if (full === 1'b1 && full_step < 0) full_step = s;
    end
    total++; if (first_ov !== 3) begin bad++; $display("FAIL sweep_first_valid got=%0d exp=3", first_ov); end
    total++; if (n_ov !== 64) begin bad++; $display("FAIL sweep_pulses got=%0d exp=64", n_ov); end
    total++; if (last_ov !== 66) begin bad++; $display("FAIL sweep_last_valid got=%0d exp=66", last_ov); end
    total++; if (out !== pat) begin bad++; $display("FAIL sweep_out got=%h exp=%h", out, pat); end
    total++; if (wr_all_step !== 66) begin bad++; $display("FAIL sweep_written_all got=%0d exp=66", wr_all_step); end
    total++; if (full_step !== 67) begin bad++; $display("FAIL sweep_full_step got=%0d exp=67", full_step); end
  endtask

  task automatic test_latency();
    do_clear();
    in_valid = 1'b1; sel = 6'd37; din = 1'b1;
    step();
    idle();
    for (int k = 1; k <= 2; k++) begin
      step();
      total++; if (out !== 64'h0) begin bad++; $display("FAIL latency_early_%0d got=%h exp=%h", k, out, 64'h0); end
    end
    step();
    total++; if (out !== 64'h0000_0020_0000_0000) begin bad++; $display("FAIL latency_out got=%h exp=%h", out, 64'h0000_0020_0000_0000); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
    total++; if (written !== 64'h0000_0020_0000_0000) begin bad++; $display("FAIL latency_written got=%h exp=%h", written, 64'h0000_0020_0000_0000); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_pulse_width got=%b exp=0", out_valid); end
    total++; if (out !== 64'h0000_0020_0000_0000) begin bad++; $display("FAIL latency_hold got=%h exp=%h", out, 64'h0000_0020_0000_0000); end
  endtask

  task automatic test_overwrite();
    do_clear();
    in_valid = 1'b1; sel = 6'd5; din = 1'b1;
    step();
    din = 1'b0;
    step();
    idle();
    step();
    step();
    total++; if (out[5] !== 1'b1) begin bad++; $display("FAIL overwrite_first got=%b exp=1", out[5]); end
    step();
    total++; if (out[5] !== 1'b0) begin bad++; $display("FAIL overwrite_second got=%b exp=0", out[5]); end
    total++; if (written !== 64'h20) begin bad++; $display("FAIL overwrite_written got=%h exp=%h", written, 64'h20); end
    step();
    total++; if (full !== 1'b0) begin bad++; $display("FAIL overwrite_full got=%b exp=0", full); end
  endtask

  task automatic test_bubbles();
    logic [2:0]  d;
    logic [63:0] exp_out;
    logic [15:0] ov_mask;
    d = 3'($urandom);
    exp_out = 64'h0;
    exp_out[10] = d[0]; exp_out[11] = d[1]; exp_out[12] = d[2];
    ov_mask = '0;
    do_clear();
    for (int s = 0; s < 12; s++) begin
      idle();
      if (s < 6) begin
        if (s % 2 == 0) begin
          in_valid = 1'b1; sel = 6'(10 + s/2); din = d[s/2];
        end else begin
          sel = 6'bxxxxxx; din = 1'bx;
        end
      end
      step();
      ov_mask[s] = out_valid;
    end
    total++; if (ov_mask !== 16'b0000_0000_1010_1000) begin bad++; $display("FAIL bubbles_pattern got=%b exp=%b", ov_mask, 16'b0000_0000_1010_1000); end
    total++; if (written !== 64'h1C00) begin bad++; $display("FAIL bubbles_written got=%h exp=%h", written, 64'h1C00); end
    total++; if (out !== exp_out) begin bad++; $display("FAIL bubbles_out got=%h exp=%h", out, exp_out); end
  endtask

  task automatic test_clear_midflight();
    int n_ov;
    do_clear();
    in_valid = 1'b1; sel = 6'd40; din = 1'b1;
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    total++; if (written !== 64'h0000_0100_0000_0000) begin bad++; $display("FAIL clear_preload got=%h exp=%h", written, 64'h0000_0100_0000_0000); end
    in_valid = 1'b1; din = 1'b1;
    sel = 6'd1; step();
    sel = 6'd2; step();
    sel = 6'd3; clear = 1'b1; step();
    idle();
    n_ov = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid !== 1'b0) n_ov++;
    end
    total++; if (out !== 64'h0) begin bad++; $display("FAIL clear_out got=%h exp=%h", out, 64'h0); end
    total++; if (written !== 64'h0) begin bad++; $display("FAIL clear_written got=%h exp=%h", written, 64'h0); end
    total++; if (n_ov !== 0) begin bad++; $display("FAIL clear_valids got=%0d exp=0", n_ov); end
  endtask

  task automatic test_reset_vs_full();
    int n_ov, budget;
    do_clear();
    for (int s = 0; s < 64; s++) begin
      in_valid = 1'b1; sel = 6'(s); din = 1'($urandom);
      step();
    end
    idle();
    budget = 0;
    while (full !== 1'b1 && budget < 10) begin step(); budget++; end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL rstfull_filled got=%b exp=1", full); end
    rst = 1'b1; in_valid = 1'b1; sel = 6'd0; din = 1'b1;
    step();
    idle();
    total++; if (out !== 64'h0) begin bad++; $display("FAIL rstfull_out got=%h exp=%h", out, 64'h0); end
    total++; if (written !== 64'h0) begin bad++; $display("FAIL rstfull_written got=%h exp=%h", written, 64'h0); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rstfull_full got=%b exp=0", full); end
    n_ov = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid !== 1'b0) n_ov++;
    end
    total++; if (n_ov !== 0 || out !== 64'h0) begin bad++; $display("FAIL rstfull_dropped got=%0d/%h exp=0/%h", n_ov, out, 64'h0); end
  endtask

  typedef struct {
    bit v;
    bit d;
    int s;
  } beat_t;

  // Reference: every accepted beat becomes visible three edges after it is
  // presented; clear wipes the word, mask and every beat not yet visible.
  task automatic test_random();
    beat_t       pipe[$];
    beat_t       b, nb;
    logic [63:0] m_out, m_wr;
    logic        m_full, m_ov, c;
    do_clear();
    m_out = '0; m_wr = '0; m_full = 1'b0; m_ov = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      nb.v = ($urandom_range(0, 3) != 0);
      nb.d = 1'($urandom);
      nb.s = (cyc < 200) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
      c    = ($urandom_range(0, 39) == 0);
      in_valid = nb.v; sel = 6'(nb.s); din = nb.d; clear = c;
      if (c) begin
        pipe.delete();
        m_out = '0; m_wr = '0; m_full = 1'b0; m_ov = 1'b0;
      end else begin
        m_full = &m_wr;
        m_ov = 1'b0;
        pipe.push_back(nb);
        if (pipe.size() > 3) begin
          b = pipe.pop_front();
          if (b.v) begin
            m_out[b.s] = b.d;
            m_wr[b.s]  = 1'b1;
            m_ov       = 1'b1;
          end
        end
      end
      step();
      total++; if (out !== m_out) begin bad++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, out, m_out); end
      total++; if (written !== m_wr) begin bad++; $display("FAIL rand_written cyc=%0d got=%h exp=%h", cyc, written, m_wr); end
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov); end
      total++; if (full !== m_full) begin bad++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, full, m_full); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_sweep();
    test_latency();
    test_overwrite();
    test_bubbles();
    test_clear_midflight();
    test_reset_vs_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
